// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared widths, state encoding and timeout default for the fetch sequencer
// Purpose: constants and the FSM state type used by every fetch_sequencer file.
package fetch_sequencer_pkg;

  localparam int AW              = 6;   // memory address / AR width
  localparam int DW              = 9;   // memory word / DR width
  localparam int OPW             = 3;   // opcode / IR width; DW = OPW + AW
  localparam int OPND_BIT        = 8;   // instruction bit that requests an operand read
  localparam int CNT_W           = 4;   // wait counter width
  localparam int TIMEOUT_DEFAULT = 15;  // wait cycles tolerated per read before abort

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_WRITE,
    S_FINISH,
    S_ABORT
  } state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - control, memory and register-load signal bundle of the fetch sequencer
// Ports (slave = sequencer side):
//   START/PC_IN            fetch request and program address
//   MEM_RD/MEM_ADDR        read request and address to memory
//   MEM_RDY/MEM_DATA       read-data-valid and read data from memory
//   IR_LD/IR_DATA          opcode register load strobe and value
//   AR_LD/AR_DATA          address register load strobe and value
//   DR_LD/DR_DATA          data register load strobe and value
//   BUSY/DONE/ERR          status: not idle, success pulse, timeout pulse
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic           START;
  logic [AW-1:0]  PC_IN;
  logic           MEM_RD;
  logic [AW-1:0]  MEM_ADDR;
  logic           MEM_RDY;
  logic [DW-1:0]  MEM_DATA;
  logic           IR_LD;
  logic [OPW-1:0] IR_DATA;
  logic           AR_LD;
  logic [AW-1:0]  AR_DATA;
  logic           DR_LD;
  logic [DW-1:0]  DR_DATA;
  logic           BUSY;
  logic           DONE;
  logic           ERR;

  modport slave (
    input  START, PC_IN, MEM_RDY, MEM_DATA,
    output MEM_RD, MEM_ADDR, IR_LD, IR_DATA, AR_LD, AR_DATA,
           DR_LD, DR_DATA, BUSY, DONE, ERR
  );

  modport master (
    output START, PC_IN, MEM_RDY, MEM_DATA,
    input  MEM_RD, MEM_ADDR, IR_LD, IR_DATA, AR_LD, AR_DATA,
           DR_LD, DR_DATA, BUSY, DONE, ERR
  );

endinterface

// File: rtl/fetch_sequencer_mem_read_port.sv
// rtl/fetch_sequencer_mem_read_port.sv - single outstanding memory read with wait counter and timeout
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   issue, issue_addr      start a read at issue_addr (ignored while a read is pending by construction)
//   mem_rdy                memory read-data-valid
//   mem_rd, mem_addr       registered read request and address
//   rd_ok                  read completes on this edge
//   rd_timeout             read is abandoned on this edge
module fetch_sequencer_mem_read_port
  import fetch_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          issue,
  input  logic [AW-1:0] issue_addr,
  input  logic          mem_rdy,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic          rd_ok,
  output logic          rd_timeout
);

  logic             rd_q, rd_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Ready on the timeout edge still counts as success.
  assign rd_ok      = rd_q & mem_rdy;
  assign rd_timeout = rd_q & ~mem_rdy & (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    rd_d   = rd_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (issue) begin
      rd_d   = 1'b1;
      addr_d = issue_addr;
      cnt_d  = '0;
    end else if (rd_ok || rd_timeout) begin
      rd_d  = 1'b0;
      cnt_d = '0;
    end else if (rd_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_q   <= 1'b0;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rd_q   <= rd_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mem_rd   = rd_q;
  assign mem_addr = addr_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetches an instruction, splits it into IR/AR and optionally loads the operand into DR
// Ports:
//   CLK, RESETN            clock, synchronous active-low reset
//   bus (slave)            START/PC_IN request, MEM_* read port, IR/AR/DR load strobes and data,
//                          BUSY/DONE/ERR status
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               CLK,
  input  logic               RESETN,
  fetch_sequencer_if.slave   bus
);

  state_e         state_q, state_d;
  logic [DW-1:0]  word_q, word_d;       // instruction word, then reused for the operand
  logic           ir_ld_q, ir_ld_d;
  logic [OPW-1:0] ir_data_q, ir_data_d;
  logic           ar_ld_q, ar_ld_d;
  logic [AW-1:0]  ar_data_q, ar_data_d;
  logic           dr_ld_q, dr_ld_d;
  logic [DW-1:0]  dr_data_q, dr_data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           issue;
  logic [AW-1:0]  issue_addr;
  logic           rd_ok;
  logic           rd_timeout;

  fetch_sequencer_mem_read_port #(
    .TIMEOUT(TIMEOUT)
  ) u_mem_read_port (
    .clk       (CLK),
    .resetn    (RESETN),
    .issue     (issue),
    .issue_addr(issue_addr),
    .mem_rdy   (bus.MEM_RDY),
    .mem_rd    (bus.MEM_RD),
    .mem_addr  (bus.MEM_ADDR),
    .rd_ok     (rd_ok),
    .rd_timeout(rd_timeout)
  );

  // Every state's action is registered, so strobes and pulses appear in the
  // cycle after the state that decides them. DATA buses only move with their LD.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    ir_ld_d    = 1'b0;
    ar_ld_d    = 1'b0;
    dr_ld_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    ir_data_d  = ir_data_q;
    ar_data_d  = ar_data_q;
    dr_data_d  = dr_data_q;
    issue      = 1'b0;
    issue_addr = bus.PC_IN;

    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          issue   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (rd_ok) begin
          word_d  = bus.MEM_DATA;
          state_d = S_DECODE;
        end else if (rd_timeout) begin
          state_d = S_ABORT;
        end
      end
      S_DECODE: begin
        ir_ld_d   = 1'b1;
        ir_data_d = word_q[DW-1 -: OPW];
        ar_ld_d   = 1'b1;
        ar_data_d = word_q[AW-1:0];
        if (word_q[OPND_BIT]) begin
          issue      = 1'b1;
          issue_addr = word_q[AW-1:0];
          state_d    = S_OPERAND;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_OPERAND: begin
        if (rd_ok) begin
          word_d  = bus.MEM_DATA;
          state_d = S_WRITE;
        end else if (rd_timeout) begin
          state_d = S_ABORT;
        end
      end
      S_WRITE: begin
        dr_ld_d   = 1'b1;
        dr_data_d = word_q;
        state_d   = S_FINISH;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      ir_ld_q   <= 1'b0;
      ir_data_q <= '0;
      ar_ld_q   <= 1'b0;
      ar_data_q <= '0;
      dr_ld_q   <= 1'b0;
      dr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      ir_ld_q   <= ir_ld_d;
      ir_data_q <= ir_data_d;
      ar_ld_q   <= ar_ld_d;
      ar_data_q <= ar_data_d;
      dr_ld_q   <= dr_ld_d;
      dr_data_q <= dr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.IR_LD   = ir_ld_q;
  assign bus.IR_DATA = ir_data_q;
  assign bus.AR_LD   = ar_ld_q;
  assign bus.AR_DATA = ar_data_q;
  assign bus.DR_LD   = dr_ld_q;
  assign bus.DR_DATA = dr_data_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.ERR     = err_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the CPU's parallel-load registers from the memory side.
- Reads the instruction word at the program address and splits it into a 3-bit opcode (IR) and a 6-bit address (AR).
- When the opcode requires it, reads the operand word at that address into the 9-bit data register (DR).
- Sits between the 6-bit-address / 9-bit-data memory port and the IR/AR/DR load inputs; generates every LD strobe and DATA bus for those registers.

Parameters:
- AW, 6, address width.
- DW, 9, data word width.
- OPW, 3, opcode width; DW = OPW + AW.
- TIMEOUT, 15, max wait cycles per memory read before abort (4-bit counter).

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RESETN  in  1  synchronous active-low reset, sampled on posedge CLK.
- START  in  1  request one fetch; sampled in IDLE only.
- PC_IN  in  AW  program address; captured on the accepted START cycle.
- MEM_RD  out  AW-independent 1  read request, held until MEM_RDY or timeout.
- MEM_ADDR  out  AW  read address, stable while MEM_RD=1.
- MEM_RDY  in  1  memory read-data-valid; meaningful only while MEM_RD=1.
- MEM_DATA  in  DW  read data, valid when MEM_RDY=1.
- IR_LD  out  1  instruction register load strobe.
- IR_DATA  out  OPW  opcode to IR.
- AR_LD  out  1  address register load strobe.
- AR_DATA  out  AW  address field to AR.
- DR_LD  out  1  data register load strobe.
- DR_DATA  out  DW  operand word to DR.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse on successful completion.
- ERR  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (RESETN=0 at posedge): state=IDLE; all outputs and the internal counter clear to 0. Reset mid-operation aborts immediately: no LD, DONE or ERR pulse is issued.
- All outputs are registered and change only on posedge CLK.
- States and transitions:
  - IDLE: if START=1, capture PC_IN, drive MEM_ADDR=PC_IN, go to FETCH. START is ignored in every other state (no queueing).
  - FETCH: MEM_RD=1. At each posedge:
    - MEM_RDY=1: latch MEM_DATA into the instruction word, drop MEM_RD, clear the counter, go to DECODE.
    - else, counter reaches TIMEOUT: go to ABORT.
    - else: counter increments.
  - DECODE (1 cycle): IR_LD=1 with IR_DATA=word[8:6]; AR_LD=1 with AR_DATA=word[5:0].
    - word[8]=1: operand required; MEM_ADDR=word[5:0], go to OPERAND.
    - word[8]=0: go to FINISH.
  - OPERAND: same handshake and timeout rules as FETCH. On MEM_RDY, latch MEM_DATA and go to WRITE.
  - WRITE (1 cycle): DR_LD=1 with DR_DATA=operand, then go to FINISH.
  - FINISH: DONE=1 for one cycle, then IDLE.
  - ABORT: ERR=1 for one cycle, no LD strobe, MEM_RD=0, then IDLE.
- Strobe and data timing:
  - Each LD strobe is high for exactly one full clock cycle.
  - The corresponding DATA bus is valid from the LD rising edge and holds its value until the next LD of the same register. This satisfies both the posedge-captured IR and the negedge-captured AR/DR.
- Latency with zero-wait memory (MEM_RDY=1 in the first FETCH/OPERAND cycle), measured from the START edge:
  - DONE 4 cycles after START without operand.
  - DONE 6 cycles after START with operand.
  - Each memory wait cycle adds 1.
- MEM_RDY while MEM_RD=0 is ignored.
- MEM_ADDR wraps naturally within 6 bits; no arithmetic is performed.
- Timeout: abort on the posedge where the wait count equals TIMEOUT, i.e. TIMEOUT+1 cycles of MEM_RD with no MEM_RDY. MEM_RDY arriving on that same edge wins (success).

Decomposition:
- Shared package:
  - state enum (IDLE, FETCH, DECODE, OPERAND, WRITE, FINISH, ABORT);
  - OPW/AW/DW constants;
  - operand-required bit index (8);
  - TIMEOUT default.
- One natural sub-module: mem_read_port. It holds the MEM_RD/MEM_ADDR handshake, wait counter and timeout flag, and is instantiated once and reused by FETCH and OPERAND.

Test Plan:
- Reset, no START -> all outputs 0, BUSY=0 indefinitely; START during reset ignored.
- PC_IN=0x05, mem[5]=9'b011_101010, zero-wait -> MEM_ADDR=0x05; IR_LD with IR_DATA=3'b011; AR_LD with AR_DATA=0x2A; no MEM_RD second read; DR_LD never; DONE 4 cycles after START.
- PC_IN=0x05, mem[5]=9'b101_000111, mem[7]=0x1FF, 2 wait cycles each read -> second read at MEM_ADDR=0x07; DR_LD with DR_DATA=0x1FF; DONE 10 cycles after START.
- MEM_RDY held 0 after START -> ERR pulse after 16 MEM_RD cycles; no LD; BUSY=0 next cycle; new START then completes normally.
- RESETN=0 asserted during OPERAND wait -> next cycle IDLE, MEM_RD=0, no DR_LD/DONE/ERR; START pulses while BUSY=1 are ignored (exactly one DONE per accepted START).
- MEM_RDY asserted on the exact timeout edge -> success path taken, no ERR.
